// File: rtl/mau_pkg.sv
// Shared definitions for the load/store initiator: op field layout, size codes,
// FSM states and the big-endian byte-lane mask helper.
package mau_pkg;

  localparam int unsigned OP_STORE    = 3;
  localparam int unsigned OP_UNSIGNED = 2;
  localparam int unsigned OP_SIZE_HI  = 1;
  localparam int unsigned OP_SIZE_LO  = 0;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  // Bit k of the mask enables big-endian byte offset k (bits [31-8k:24-8k]).
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] offset);
    logic [3:0] m;
    m = '0;
    case (size)
      SZ_BYTE: m = 4'b0001 << offset;
      SZ_HALF: m = offset[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: m = '1;
      default: m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/mau_load_align.sv
// Combinational load lane select and sign/zero extension for big-endian
// byte and halfword loads out of a 32-bit memory word.
module mau_load_align
  import mau_pkg::*;
(
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = '0;
    case (offset)
      2'd0: byte_sel = mem_rdata[31:24];
      2'd1: byte_sel = mem_rdata[23:16];
      2'd2: byte_sel = mem_rdata[15:8];
      2'd3: byte_sel = mem_rdata[7:0];
      default: byte_sel = '0;
    endcase
    half_sel = offset[1] ? mem_rdata[15:0] : mem_rdata[31:16];

    result = '0;
    case (size)
      SZ_BYTE: result = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SZ_HALF: result = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      SZ_WORD: result = mem_rdata;
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator between the core datapath and the word-wide data memory.
// Optional saturating response counters are enabled with `define MAU_STATS_EN.
module mem_access_unit
  import mau_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h10010000,
  parameter int unsigned MEM_WORDS = 2048,
  localparam int unsigned AW       = $clog2(MEM_WORDS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [3:0]    req_op,
  input  logic [31:0]   req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_err,
  output logic          mem_en,
  output logic [3:0]    mem_write,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata
`ifdef MAU_STATS_EN
  ,
  output logic [31:0]   stat_loads,
  output logic [31:0]   stat_stores,
  output logic [31:0]   stat_errs
`endif
);

  localparam logic [31:0] SPAN = 32'(4 * MEM_WORDS);

  state_t        state, state_nxt;
  logic [3:0]    op_q;
  logic [1:0]    offs_q;
  logic [AW-1:0] widx_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;

  logic [31:0]   req_off;
  logic          req_bad;
  logic [1:0]    size_q;
  logic [31:0]   store_data;
  logic [31:0]   load_data;

  assign size_q    = op_q[OP_SIZE_HI:OP_SIZE_LO];
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

  // Wrapping subtraction makes addresses below the base land far out of range.
  always_comb begin
    req_off = req_addr - BASE_ADDR;
    req_bad = (req_off >= SPAN);
    case (req_op[OP_SIZE_HI:OP_SIZE_LO])
      SZ_BYTE: ;
      SZ_HALF: if (req_addr[0]) req_bad = 1'b1;
      SZ_WORD: if (req_addr[1:0] != 2'b00) req_bad = 1'b1;
      default: req_bad = 1'b1;
    endcase
  end

  always_comb begin
    case (size_q)
      SZ_BYTE: store_data = {4{wdata_q[7:0]}};
      SZ_HALF: store_data = {2{wdata_q[15:0]}};
      default: store_data = wdata_q;
    endcase
  end

  mau_load_align u_load_align (
    .mem_rdata   (mem_rdata),
    .offset      (offs_q),
    .size        (size_q),
    .is_unsigned (op_q[OP_UNSIGNED]),
    .result      (load_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Memory strobes decode straight from state so reset kills them mid-access.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    mem_en    = 1'b0;
    mem_write = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_bad ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        mem_en    = 1'b1;
        mem_addr  = widx_q;
        mem_wdata = store_data;
        if (op_q[OP_STORE]) mem_write = lane_mask(size_q, offs_q);
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      offs_q  <= '0;
      widx_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == ST_IDLE && req_valid) begin
      op_q    <= req_op;
      offs_q  <= req_addr[1:0];
      widx_q  <= req_off[AW+1:2];
      wdata_q <= req_wdata;
      rdata_q <= '0;
      err_q   <= req_bad;
    end else if (state == ST_ACCESS) begin
      rdata_q <= op_q[OP_STORE] ? '0 : load_data;
    end
  end

`ifdef MAU_STATS_EN
  logic consume;
  assign consume = rsp_valid & rsp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_loads  <= '0;
      stat_stores <= '0;
      stat_errs   <= '0;
    end else if (consume) begin
      if (err_q) begin
        if (stat_errs != '1) stat_errs <= stat_errs + 32'd1;
      end else if (op_q[OP_STORE]) begin
        if (stat_stores != '1) stat_stores <= stat_stores + 32'd1;
      end else begin
        if (stat_loads != '1) stat_loads <= stat_loads + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: byte-array reference memory model,
// directed table from the test plan, randomized traffic, backpressure and reset.
module tb_mem_access_unit;

  localparam logic [31:0] BASE  = 32'h10010000;
  localparam int          WORDS = 2048;
  localparam int          AW    = 11;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [3:0]    req_op = '0;
  logic [31:0]   req_addr = '0;
  logic [31:0]   req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          mem_en;
  logic [3:0]    mem_write;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;
`ifdef MAU_STATS_EN
  logic [31:0]   stat_loads, stat_stores, stat_errs;
`endif

  int checks = 0;
  int errors = 0;
  int m_loads = 0, m_stores = 0, m_errs = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.BASE_ADDR(BASE), .MEM_WORDS(WORDS)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MAU_STATS_EN
    , .stat_loads(stat_loads), .stat_stores(stat_stores), .stat_errs(stat_errs)
`endif
  );

  // Word memory the DUT talks to; read is combinational while enabled.
  logic [31:0] mem_w [0:WORDS-1];
  logic [31:0] nw;
  assign mem_rdata = mem_en ? mem_w[mem_addr] : 32'hA5A5A5A5;
  always @(posedge clk) begin
    if (mem_en && mem_write != 4'b0000) begin
      nw = mem_w[mem_addr];
      for (int k = 0; k < 4; k++)
        if (mem_write[k]) nw[31-8*k -: 8] = mem_wdata[31-8*k -: 8];
      mem_w[mem_addr] <= nw;
    end
  end

  // Reference: flat big-endian byte array indexed by offset from the base.
  logic [7:0] ref_b [0:4*WORDS-1];

  typedef struct {
    int          en_cnt;
    logic [3:0]  wr;
    logic [31:0] wdat;
    logic [AW-1:0] madr;
    int          lat;
    logic [31:0] rd;
    logic        er;
  } obs_t;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wd;
    bit          chk;
    logic [31:0] rd;
  } dir_t;

  task automatic model_txn(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           output logic e, output logic [31:0] rd, output logic [3:0] mask,
                           output logic [31:0] wdat, output int idx);
    logic [31:0] off;
    logic [31:0] v;
    int n, k;
    off  = addr - BASE;
    n    = (op[1:0] == 2'd0) ? 1 : (op[1:0] == 2'd1) ? 2 : 4;
    k    = int'(addr[1:0]);
    e    = (op[1:0] == 2'b11) || (n == 2 && addr[0]) || (n == 4 && addr[1:0] != 2'b00) ||
           (off >= 32'(4 * WORDS));
    rd   = '0;
    mask = '0;
    wdat = '0;
    idx  = int'(off >> 2);
    if (!e) begin
      if (op[3]) begin
        for (int j = 0; j < 4; j++) begin
          if (j >= k && j < k + n) mask[j] = 1'b1;
          wdat[31-8*j -: 8] = wd[8*(n-1-(j % n)) +: 8];
        end
        for (int i = 0; i < n; i++) ref_b[int'(off) + i] = wd[8*(n-1-i) +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v = (v << 8) | 32'(ref_b[int'(off) + i]);
        if (n < 4 && !op[2] && v[8*n-1]) v = v | (32'hFFFFFFFF << (8 * n));
        rd = v;
      end
    end
    if (e) m_errs++;
    else if (op[3]) m_stores++;
    else m_loads++;
  endtask

  // Drive one request with rsp_ready high and record what the DUT did.
  task automatic run_req(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] wd,
                         output obs_t o);
    int n;
    o.en_cnt = 0; o.wr = '0; o.wdat = '0; o.madr = '0; o.lat = 0; o.rd = '0; o.er = 1'b0;
    @(negedge clk);
    req_op = op; req_addr = addr; req_wdata = wd; req_valid = 1'b1; rsp_ready = 1'b1;
    n = 0;
    while (!req_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (mem_en) begin
        o.en_cnt++; o.wr = mem_write; o.wdat = mem_wdata; o.madr = mem_addr;
      end
      if (rsp_valid) begin
        o.lat = c; o.rd = rsp_rdata; o.er = rsp_err;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, rsp_valid, rsp_err, mem_en} !== 4'b1000) begin
      errors++; $display("FAIL reset_ctrl got %b want 1000", {req_ready, rsp_valid, rsp_err, mem_en});
    end
    checks++;
    if ({rsp_rdata, mem_write, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL reset_data rdata=%h wr=%b addr=%h wdata=%h want all 0",
                         rsp_rdata, mem_write, mem_addr, mem_wdata);
    end
`ifdef MAU_STATS_EN
    checks++;
    if ({stat_loads, stat_stores, stat_errs} !== '0) begin
      errors++; $display("FAIL reset_stats got %0d %0d %0d want 0", stat_loads, stat_stores, stat_errs);
    end
`endif
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    dir_t tbl [$];
    obs_t o;
    logic e; logic [31:0] rd, wdat; logic [3:0] mask; int idx;
    tbl.push_back('{4'b1010, 32'h10010004, 32'hDEADBEEF, 1'b0, 32'h0});
    tbl.push_back('{4'b0010, 32'h10010004, 32'h0,        1'b1, 32'hDEADBEEF});
    tbl.push_back('{4'b1000, 32'h10010003, 32'h00000080, 1'b0, 32'h0});
    tbl.push_back('{4'b0000, 32'h10010003, 32'h0,        1'b1, 32'hFFFFFF80});
    tbl.push_back('{4'b0100, 32'h10010003, 32'h0,        1'b1, 32'h00000080});
    tbl.push_back('{4'b1001, 32'h10010002, 32'h00001234, 1'b0, 32'h0});
    tbl.push_back('{4'b0001, 32'h10010002, 32'h0,        1'b1, 32'h00001234});
    tbl.push_back('{4'b0001, 32'h10010001, 32'h0,        1'b1, 32'h0});
    tbl.push_back('{4'b0010, 32'h10012000, 32'h0,        1'b1, 32'h0});
    tbl.push_back('{4'b0010, 32'h1000FFFC, 32'h0,        1'b1, 32'h0});
    tbl.push_back('{4'b0011, 32'h10010000, 32'h0,        1'b1, 32'h0});
    tbl.push_back('{4'b0010, 32'h10011FFC, 32'h0,        1'b1, 32'h0});
    tbl.push_back('{4'b1000, 32'h10010000, 32'hFFFFFF7F, 1'b0, 32'h0});
    tbl.push_back('{4'b0000, 32'h10010000, 32'h0,        1'b1, 32'h0000007F});
    tbl.push_back('{4'b0101, 32'h10010000, 32'h0,        1'b1, 32'h00007F00});
    foreach (tbl[i]) begin
      model_txn(tbl[i].op, tbl[i].addr, tbl[i].wd, e, rd, mask, wdat, idx);
      run_req(tbl[i].op, tbl[i].addr, tbl[i].wd, o);
      checks++;
      if (o.er !== e || o.lat != (e ? 1 : 2)) begin
        errors++; $display("FAIL dir%0d_err_lat got err=%b lat=%0d want err=%b lat=%0d",
                           i, o.er, o.lat, e, e ? 1 : 2);
      end
      checks++;
      if (o.rd !== rd || (tbl[i].chk && o.rd !== tbl[i].rd)) begin
        errors++; $display("FAIL dir%0d_rdata got %h want %h (table %h)", i, o.rd, rd, tbl[i].rd);
      end
      checks++;
      if (o.en_cnt != (e ? 0 : 1) || (!e && (o.wr !== mask || o.madr !== AW'(idx)))) begin
        errors++; $display("FAIL dir%0d_access got en=%0d wr=%b addr=%0d want en=%0d wr=%b addr=%0d",
                           i, o.en_cnt, o.wr, o.madr, e ? 0 : 1, mask, idx);
      end
      if (!e && tbl[i].op[3]) begin
        checks++;
        if (o.wdat !== wdat) begin
          errors++; $display("FAIL dir%0d_wdata got %h want %h", i, o.wdat, wdat);
        end
      end
    end
  endtask

  task automatic test_random();
    obs_t o;
    logic e; logic [31:0] rd, wdat, addr, wd; logic [3:0] mask, op; int idx, r;
    for (int t = 0; t < 80; t++) begin
      op[3]   = 1'($urandom_range(0, 1));
      op[2]   = 1'($urandom_range(0, 1));
      op[1:0] = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      r = $urandom_range(0, 9);
      if (r < 7) begin
        addr = BASE + ((r < 4) ? 32'($urandom_range(0, 63)) : 32'($urandom_range(0, 4*WORDS-1)));
        if (r < 5) addr = addr & ~32'((op[1:0] == 2'd1) ? 1 : (op[1:0] == 2'd2) ? 3 : 0);
      end else if (r == 7) addr = $urandom;
      else if (r == 8) addr = BASE + 32'(4 * WORDS) + 32'($urandom_range(0, 15));
      else addr = BASE - 32'd1 - 32'($urandom_range(0, 15));
      wd = $urandom;
      model_txn(op, addr, wd, e, rd, mask, wdat, idx);
      run_req(op, addr, wd, o);
      checks++;
      if (o.er !== e || o.rd !== rd || o.lat != (e ? 1 : 2)) begin
        errors++; $display("FAIL rnd%0d_rsp op=%b addr=%h got err=%b rd=%h lat=%0d want err=%b rd=%h lat=%0d",
                           t, op, addr, o.er, o.rd, o.lat, e, rd, e ? 1 : 2);
      end
      checks++;
      if (o.en_cnt != (e ? 0 : 1) ||
          (!e && (o.wr !== mask || o.madr !== AW'(idx) || (op[3] && o.wdat !== wdat)))) begin
        errors++; $display("FAIL rnd%0d_access op=%b addr=%h got en=%0d wr=%b a=%0d wd=%h want wr=%b a=%0d wd=%h",
                           t, op, addr, o.en_cnt, o.wr, o.madr, o.wdat, mask, idx, wdat);
      end
    end
  endtask

  task automatic test_backpressure();
    logic e; logic [31:0] rd, wdat; logic [3:0] mask; int idx, c;
    model_txn(4'b0010, 32'h10010004, 32'h0, e, rd, mask, wdat, idx);
    @(negedge clk);
    req_op = 4'b0010; req_addr = 32'h10010004; req_valid = 1'b1; rsp_ready = 1'b0;
    @(posedge clk); #1;
    req_op = 4'b1010; req_addr = 32'h10010008; req_wdata = 32'hCAFEF00D;
    c = 0;
    while (!rsp_valid && c < 5) begin
      @(posedge clk); #1;
      c++;
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({rsp_valid, req_ready, mem_en} !== 3'b100 || rsp_rdata !== rd) begin
        errors++; $display("FAIL bp_hold%0d got v=%b rdy=%b en=%b rd=%h want v=1 rdy=0 en=0 rd=%h",
                           i, rsp_valid, req_ready, mem_en, rsp_rdata, rd);
      end
      @(posedge clk); #1;
    end
    @(negedge clk);
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, req_ready} !== 2'b01) begin
      errors++; $display("FAIL bp_release got v=%b rdy=%b want v=0 rdy=1", rsp_valid, req_ready);
    end
    checks++;
    if (mem_w[2] !== {ref_b[8], ref_b[9], ref_b[10], ref_b[11]}) begin
      errors++; $display("FAIL bp_ignored_store mem=%h want %h", mem_w[2],
                         {ref_b[8], ref_b[9], ref_b[10], ref_b[11]});
    end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    logic e; logic [31:0] rd, wdat; logic [3:0] mask; int idx;
    @(negedge clk);
    req_op = 4'b1010; req_addr = 32'h10010004; req_wdata = 32'h11111111;
    req_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checks++;
    if (mem_en !== 1'b1 || mem_write !== 4'b1111) begin
      errors++; $display("FAIL rst_mid_pre got en=%b wr=%b want en=1 wr=1111", mem_en, mem_write);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_en, mem_write, req_ready, rsp_valid, rsp_err} !== 8'b0_0000_100 ||
        {rsp_rdata, mem_addr, mem_wdata} !== '0) begin
      errors++; $display("FAIL rst_mid_outputs got en=%b wr=%b rdy=%b v=%b err=%b rd=%h a=%h wd=%h",
                         mem_en, mem_write, req_ready, rsp_valid, rsp_err, rsp_rdata, mem_addr, mem_wdata);
    end
    m_loads = 0; m_stores = 0; m_errs = 0;
    @(posedge clk); #1;
    @(negedge clk);
    rst_n = 1'b1;
    checks++;
    if (mem_w[1] !== {ref_b[4], ref_b[5], ref_b[6], ref_b[7]}) begin
      errors++; $display("FAIL rst_mid_mem got %h want %h", mem_w[1], {ref_b[4], ref_b[5], ref_b[6], ref_b[7]});
    end
`ifdef MAU_STATS_EN
    checks++;
    if ({stat_loads, stat_stores, stat_errs} !== '0) begin
      errors++; $display("FAIL rst_mid_stats got %0d %0d %0d want 0", stat_loads, stat_stores, stat_errs);
    end
`endif
    model_txn(4'b0010, 32'h10010004, 32'h0, e, rd, mask, wdat, idx);
    run_req(4'b0010, 32'h10010004, 32'h0, o);
    checks++;
    if (o.rd !== rd || o.er !== 1'b0) begin
      errors++; $display("FAIL rst_mid_reload got rd=%h err=%b want rd=%h err=0", o.rd, o.er, rd);
    end
  endtask

`ifdef MAU_STATS_EN
  task automatic test_stats();
    checks++;
    if (stat_loads !== 32'(m_loads) || stat_stores !== 32'(m_stores) || stat_errs !== 32'(m_errs)) begin
      errors++; $display("FAIL stats got l=%0d s=%0d e=%0d want l=%0d s=%0d e=%0d",
                         stat_loads, stat_stores, stat_errs, m_loads, m_stores, m_errs);
    end
  endtask
`endif

  initial begin
    for (int i = 0; i < WORDS; i++) mem_w[i] = '0;
    for (int i = 0; i < 4 * WORDS; i++) ref_b[i] = '0;
    test_reset();
    m_loads = 0; m_stores = 0; m_errs = 0;
    test_directed();
    test_backpressure();
    test_random();
`ifdef MAU_STATS_EN
    test_stats();
`endif
    test_reset_mid_access();
`ifdef MAU_STATS_EN
    test_stats();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
